// File: rtl/huff_freq_sorter.sv
// Counts occurrences of each distinct input symbol, odd-even sorts (weight, symbol) ascending,
// then streams the pairs out under valid/ready; input is accepted only while collecting.
module huff_freq_sorter #(
  parameter int SYM_W   = 8,
  parameter int MAX_SYM = 32,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [SYM_W-1:0]              in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SYM_W-1:0]              out_sym,
  output logic [CNT_W-1:0]              out_weight,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(MAX_SYM+1)-1:0]  nsym
);
  localparam int NS_W = $clog2(MAX_SYM + 1);
  localparam int IX_W = $clog2(MAX_SYM);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SORT, S_OUT} state_t;

  state_t           r_state, w_state_nxt;
  logic [SYM_W-1:0] r_sym [MAX_SYM];
  logic [CNT_W-1:0] r_wgt [MAX_SYM];
  logic [SYM_W-1:0] w_sort_sym [MAX_SYM];
  logic [CNT_W-1:0] w_sort_wgt [MAX_SYM];
  logic [NS_W-1:0]  r_nsym, r_idx;
  logic [IX_W-1:0]  r_cnt, w_hit_idx;
  logic             r_out_valid, r_done, r_overflow;
  logic             w_accept, w_hit, w_out_hs, w_last_idx, w_sort_end;

  assign w_accept   = in_valid && (r_state == S_COLLECT);
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_last_idx = (r_idx == r_nsym - NS_W'(1));
  assign w_sort_end = (r_cnt == IX_W'(MAX_SYM - 1));

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int j = 0; j < MAX_SYM; j++) begin
      if (NS_W'(j) < r_nsym && r_sym[j] == in_data) begin
        w_hit     = 1'b1;
        w_hit_idx = IX_W'(j);
      end
    end
  end

  // Entries at or above nsym stay at the top, so only pairs fully below nsym may swap.
  always_comb begin
    for (int j = 0; j < MAX_SYM; j++) begin
      w_sort_sym[j] = r_sym[j];
      w_sort_wgt[j] = r_wgt[j];
    end
    for (int j = 0; j < MAX_SYM - 1; j++) begin
      if ((j % 2) == int'(r_cnt[0]) && NS_W'(j + 1) < r_nsym &&
          (r_wgt[j] > r_wgt[j+1] || (r_wgt[j] == r_wgt[j+1] && r_sym[j] > r_sym[j+1]))) begin
        w_sort_sym[j]   = r_sym[j+1];
        w_sort_wgt[j]   = r_wgt[j+1];
        w_sort_sym[j+1] = r_sym[j];
        w_sort_wgt[j+1] = r_wgt[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_accept && in_last) w_state_nxt = S_SORT;
      S_SORT:    if (w_sort_end) w_state_nxt = S_OUT;
      S_OUT:     if (w_out_hs && w_last_idx) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_COLLECT);
    busy       = (r_state != S_IDLE);
    out_valid  = r_out_valid;
    out_sym    = r_out_valid ? r_sym[r_idx[IX_W-1:0]] : '0;
    out_weight = r_out_valid ? r_wgt[r_idx[IX_W-1:0]] : '0;
    out_last   = r_out_valid && w_last_idx;
    done       = r_done;
    overflow   = r_overflow;
    nsym       = r_nsym;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < MAX_SYM; j++) begin
        r_sym[j] <= '0;
        r_wgt[j] <= '0;
      end
      r_nsym      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j < MAX_SYM; j++) begin
              r_sym[j] <= '0;
              r_wgt[j] <= '0;
            end
            r_nsym     <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_cnt <= '0;
          if (w_accept) begin
            if (w_hit) begin
              if (r_wgt[w_hit_idx] != '1) r_wgt[w_hit_idx] <= r_wgt[w_hit_idx] + CNT_W'(1);
            end else if (r_nsym != NS_W'(MAX_SYM)) begin
              r_sym[r_nsym[IX_W-1:0]] <= in_data;
              r_wgt[r_nsym[IX_W-1:0]] <= CNT_W'(1);
              r_nsym                  <= r_nsym + NS_W'(1);
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        S_SORT: begin
          r_cnt <= r_cnt + IX_W'(1);
          for (int j = 0; j < MAX_SYM; j++) begin
            r_sym[j] <= w_sort_sym[j];
            r_wgt[j] <= w_sort_wgt[j];
          end
          if (w_sort_end) begin
            r_out_valid <= 1'b1;
            r_idx       <= '0;
          end
        end
        S_OUT: begin
          if (w_out_hs) begin
            if (w_last_idx) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx <= r_idx + NS_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_freq_sorter.sv
module tb_huff_freq_sorter;
  localparam int SYM_W   = 8;
  localparam int MAX_SYM = 4;
  localparam int CNT_W   = 8;
  localparam int NS_W    = $clog2(MAX_SYM + 1);

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [SYM_W-1:0] in_data = '0;
  logic             in_ready, out_valid, out_last, busy, done, overflow;
  logic [SYM_W-1:0] out_sym;
  logic [CNT_W-1:0] out_weight;
  logic [NS_W-1:0]  nsym;

  huff_freq_sorter #(.SYM_W(SYM_W), .MAX_SYM(MAX_SYM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_weight(out_weight), .out_last(out_last), .busy(busy),
    .done(done), .overflow(overflow), .nsym(nsym)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] stim[$];
  logic [7:0] exp_sym[$], exp_wgt[$], got_sym[$], got_wgt[$];
  logic       exp_last[$], got_last[$];
  int         exp_nsym;
  logic       exp_ovf;
  int         stall_err;
  logic       done_a, done_b, timeout;

  // Reference model: first-seen table with saturating counts, then a plain selection sort.
  task automatic build_expect();
    logic [7:0] s[$];
    int w[$];
    logic ovf = 1'b0;
    logic [7:0] ts;
    int tw;
    exp_sym.delete(); exp_wgt.delete(); exp_last.delete();
    foreach (stim[k]) begin
      int f = -1;
      foreach (s[j]) if (s[j] == stim[k]) f = j;
      if (f >= 0) begin
        if (w[f] < (1 << CNT_W) - 1) w[f] = w[f] + 1;
      end else if (s.size() < MAX_SYM) begin
        s.push_back(stim[k]); w.push_back(1);
      end else ovf = 1'b1;
    end
    for (int a = 0; a < s.size(); a++)
      for (int b = a + 1; b < s.size(); b++)
        if (w[b] < w[a] || (w[b] == w[a] && s[b] < s[a])) begin
          ts = s[a]; s[a] = s[b]; s[b] = ts;
          tw = w[a]; w[a] = w[b]; w[b] = tw;
        end
    foreach (s[a]) begin
      exp_sym.push_back(s[a]);
      exp_wgt.push_back(8'(w[a]));
      exp_last.push_back(a == s.size() - 1);
    end
    exp_nsym = s.size();
    exp_ovf  = ovf;
  endtask

  task automatic drive_block();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    foreach (stim[k]) begin
      in_valid = 1'b1; in_data = stim[k]; in_last = (k == stim.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect_out(input bit bp);
    logic prev_stall = 1'b0;
    logic [7:0] ps = '0, pw = '0;
    bit fin = 0;
    got_sym.delete(); got_wgt.delete(); got_last.delete();
    stall_err = 0; timeout = 1'b1; done_a = 1'b0; done_b = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge clk); #1 out_ready = bp ? ~out_ready : 1'b1;
      @(negedge clk);
      if (prev_stall && out_valid && (out_sym !== ps || out_weight !== pw)) stall_err++;
      prev_stall = out_valid && !out_ready; ps = out_sym; pw = out_weight;
      if (out_valid && out_ready) begin
        got_sym.push_back(out_sym); got_wgt.push_back(out_weight); got_last.push_back(out_last);
        if (out_last) fin = 1;
      end
    end
    if (fin) begin
      timeout = 1'b0;
      @(negedge clk); done_a = done;
      @(negedge clk); done_b = done;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 8'h21;
    @(posedge clk); #1 in_data = 8'h22;
    @(posedge clk); #1 in_valid = 1'b0;
    n_chk++; if ({busy, in_ready, nsym} !== {1'b1, 1'b1, NS_W'(2)})
      $display("FAIL reset_pre busy/in_ready/nsym got %b/%b/%0d exp 1/1/2", busy, in_ready, nsym);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_chk++; if ({in_ready, out_valid, out_sym, out_weight, out_last, busy, done, overflow, nsym} !== '0)
      $display("FAIL reset_outputs got rdy=%b vld=%b sym=%h w=%0d last=%b busy=%b done=%b ovf=%b nsym=%0d exp all 0",
               in_ready, out_valid, out_sym, out_weight, out_last, busy, done, overflow, nsym);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    stim = '{8'h41, 8'h41, 8'h42, 8'h43, 8'h43, 8'h43};
    build_expect(); drive_block(); collect_out(0);
    n_chk++; if (timeout !== 1'b0 || got_sym.size() != exp_sym.size())
      $display("FAIL basic_count got %0d pairs timeout=%b exp %0d", got_sym.size(), timeout, exp_sym.size());
    else n_pass++;
    foreach (exp_sym[k]) begin
      n_chk++;
      if (k >= got_sym.size() || {got_sym[k], got_wgt[k], got_last[k]} !== {exp_sym[k], exp_wgt[k], exp_last[k]})
        $display("FAIL basic_pair%0d got %h/%0d/%b exp %h/%0d/%b", k, (k < got_sym.size()) ? got_sym[k] : 8'hxx,
                 (k < got_sym.size()) ? got_wgt[k] : 8'hxx, (k < got_sym.size()) ? got_last[k] : 1'bx,
                 exp_sym[k], exp_wgt[k], exp_last[k]);
      else n_pass++;
    end
    n_chk++; if ({done_a, done_b} !== 2'b10) $display("FAIL basic_done got %b%b exp 10", done_a, done_b); else n_pass++;
    n_chk++; if (nsym !== NS_W'(exp_nsym) || busy !== 1'b0)
      $display("FAIL basic_nsym_busy got %0d/%b exp %0d/0", nsym, busy, exp_nsym);
    else n_pass++;
  endtask

  task automatic test_tie_backpressure();
    stim = '{8'h05, 8'h03};
    build_expect(); drive_block(); collect_out(1);
    foreach (exp_sym[k]) begin
      n_chk++;
      if (k >= got_sym.size() || {got_sym[k], got_wgt[k], got_last[k]} !== {exp_sym[k], exp_wgt[k], exp_last[k]})
        $display("FAIL tie_pair%0d got %h/%0d/%b exp %h/%0d/%b", k, (k < got_sym.size()) ? got_sym[k] : 8'hxx,
                 (k < got_sym.size()) ? got_wgt[k] : 8'hxx, (k < got_sym.size()) ? got_last[k] : 1'bx,
                 exp_sym[k], exp_wgt[k], exp_last[k]);
      else n_pass++;
    end
    n_chk++; if (timeout !== 1'b0 || got_sym.size() != 2) $display("FAIL tie_count got %0d exp 2", got_sym.size()); else n_pass++;
    n_chk++; if (stall_err != 0) $display("FAIL tie_stall_stable got %0d changes exp 0", stall_err); else n_pass++;
  endtask

  task automatic test_overflow();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_expect(); drive_block(); collect_out(0);
    foreach (exp_sym[k]) begin
      n_chk++;
      if (k >= got_sym.size() || {got_sym[k], got_wgt[k], got_last[k]} !== {exp_sym[k], exp_wgt[k], exp_last[k]})
        $display("FAIL ovf_pair%0d got %h/%0d/%b exp %h/%0d/%b", k, (k < got_sym.size()) ? got_sym[k] : 8'hxx,
                 (k < got_sym.size()) ? got_wgt[k] : 8'hxx, (k < got_sym.size()) ? got_last[k] : 1'bx,
                 exp_sym[k], exp_wgt[k], exp_last[k]);
      else n_pass++;
    end
    n_chk++; if (overflow !== 1'b1 || nsym !== NS_W'(MAX_SYM))
      $display("FAIL ovf_flag_nsym got %b/%0d exp 1/%0d", overflow, nsym, MAX_SYM);
    else n_pass++;
  endtask

  task automatic test_saturation();
    stim.delete();
    repeat (300) stim.push_back(8'h11);
    build_expect(); drive_block(); collect_out(0);
    n_chk++;
    if (timeout !== 1'b0 || got_sym.size() != 1 || {got_sym[0], got_wgt[0], got_last[0]} !== {8'h11, 8'd255, 1'b1})
      $display("FAIL sat_pair got n=%0d %h/%0d exp 1 pair 11/255/1", got_sym.size(),
               (got_sym.size() > 0) ? got_sym[0] : 8'hxx, (got_sym.size() > 0) ? got_wgt[0] : 8'hxx);
    else n_pass++;
  endtask

  task automatic test_abort();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    drive_block();
    n_chk++; if ({busy, in_ready, out_valid, overflow} !== 4'b1001)
      $display("FAIL abort_sorting got busy/rdy/vld/ovf %b%b%b%b exp 1001", busy, in_ready, out_valid, overflow);
    else n_pass++;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_chk++; if ({busy, out_valid, overflow, nsym} !== '0)
      $display("FAIL abort_reset got busy=%b vld=%b ovf=%b nsym=%0d exp 0", busy, out_valid, overflow, nsym);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    stim = '{8'h07};
    build_expect(); drive_block(); collect_out(0);
    n_chk++;
    if (timeout !== 1'b0 || got_sym.size() != 1 || {got_sym[0], got_wgt[0], got_last[0]} !== {8'h07, 8'd1, 1'b1})
      $display("FAIL abort_pair got n=%0d %h/%0d exp 1 pair 07/1/1", got_sym.size(),
               (got_sym.size() > 0) ? got_sym[0] : 8'hxx, (got_sym.size() > 0) ? got_wgt[0] : 8'hxx);
    else n_pass++;
    n_chk++; if (overflow !== 1'b0 || nsym !== NS_W'(1)) $display("FAIL abort_ovf got %b/%0d exp 0/1", overflow, nsym); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      stim.delete();
      repeat ($urandom_range(1, 24)) stim.push_back(8'h30 + 8'($urandom_range(0, 5)));
      build_expect(); drive_block(); collect_out(b[0]);
      n_chk++; if (timeout !== 1'b0 || got_sym.size() != exp_sym.size())
        $display("FAIL rand%0d_count got %0d exp %0d", b, got_sym.size(), exp_sym.size());
      else n_pass++;
      foreach (exp_sym[k]) begin
        n_chk++;
        if (k >= got_sym.size() || {got_sym[k], got_wgt[k], got_last[k]} !== {exp_sym[k], exp_wgt[k], exp_last[k]})
          $display("FAIL rand%0d_pair%0d got %h/%0d/%b exp %h/%0d/%b", b, k, (k < got_sym.size()) ? got_sym[k] : 8'hxx,
                   (k < got_sym.size()) ? got_wgt[k] : 8'hxx, (k < got_sym.size()) ? got_last[k] : 1'bx,
                   exp_sym[k], exp_wgt[k], exp_last[k]);
        else n_pass++;
      end
      n_chk++; if (overflow !== exp_ovf || nsym !== NS_W'(exp_nsym) || stall_err != 0)
        $display("FAIL rand%0d_status got ovf=%b nsym=%0d stall=%0d exp %b/%0d/0", b, overflow, nsym, stall_err, exp_ovf, exp_nsym);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_backpressure();
    test_overflow();
    test_saturation();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
